// File: rtl/aes_ciphertext_sink_fsm.sv
// AES HWPE ciphertext sink controller.
// Takes 128-bit ciphertext blocks from the engine and starts one sink
// streamer transfer per block. Each block goes out as four 32-bit words on a
// valid/ready stream, lowest word first. The controller counts written blocks
// against the job length and pulses done_o when the job is complete.
module aes_ciphertext_sink_fsm #(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   nb_blocks_i,
  input  logic [31:0]            base_addr_i,
  input  logic [BLOCK_WIDTH-1:0] block_data_i,
  input  logic                   block_valid_i,
  output logic                   block_ready_o,
  output logic                   sink_req_start_o,
  output logic [31:0]            sink_base_addr_o,
  output logic [CNT_WIDTH-1:0]   sink_trans_size_o,
  input  logic                   sink_ready_start_i,
  input  logic                   sink_done_i,
  output logic [WORD_WIDTH-1:0]  stream_data_o,
  output logic                   stream_valid_o,
  input  logic                   stream_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   blk_cnt_o
);

  localparam int unsigned NB_WORDS   = BLOCK_WIDTH / WORD_WIDTH;
  localparam int unsigned WC_WIDTH   = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned ADDR_SHIFT = $clog2(BLOCK_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLOCK,
    REQUEST,
    STREAM,
    WAIT_DONE,
    FINISHED
  } state_e;

  state_e                 state_q,     state_d;
  logic [BLOCK_WIDTH-1:0] hold_q,      hold_d;
  logic [WC_WIDTH-1:0]    wc_q,        wc_d;
  logic [CNT_WIDTH-1:0]   blk_cnt_q,   blk_cnt_d;
  logic [CNT_WIDTH-1:0]   nb_blocks_q, nb_blocks_d;
  logic [31:0]            base_q,      base_d;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      wc_q        <= '0;
      blk_cnt_q   <= '0;
      nb_blocks_q <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wc_q        <= wc_d;
      blk_cnt_q   <= blk_cnt_d;
      nb_blocks_q <= nb_blocks_d;
      base_q      <= base_d;
    end
  end

  // Next-state and datapath update; clear behaves exactly like reset
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wc_d        = wc_q;
    blk_cnt_d   = blk_cnt_q;
    nb_blocks_d = nb_blocks_q;
    base_d      = base_q;
    if (clear) begin
      state_d     = IDLE;
      hold_d      = '0;
      wc_d        = '0;
      blk_cnt_d   = '0;
      nb_blocks_d = '0;
      base_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            nb_blocks_d = nb_blocks_i;
            base_d      = base_addr_i;
            blk_cnt_d   = '0;
            state_d     = (nb_blocks_i == '0) ? FINISHED : WAIT_BLOCK;
          end
        end
        WAIT_BLOCK: begin
          if (block_valid_i) begin
            hold_d  = block_data_i;
            state_d = REQUEST;
          end
        end
        REQUEST: begin
          if (sink_ready_start_i) begin
            wc_d    = '0;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (stream_ready_i) begin
            if (wc_q == WC_WIDTH'(NB_WORDS - 1)) begin
              state_d = WAIT_DONE;
            end else begin
              wc_d = wc_q + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (sink_done_i) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
            state_d   = (blk_cnt_q + 1'b1 == nb_blocks_q) ? FINISHED : WAIT_BLOCK;
          end
        end
        FINISHED: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    block_ready_o     = 1'b0;
    sink_req_start_o  = 1'b0;
    sink_base_addr_o  = '0;
    stream_valid_o    = 1'b0;
    stream_data_o     = '0;
    done_o            = 1'b0;
    busy_o            = (state_q != IDLE);
    blk_cnt_o         = blk_cnt_q;
    sink_trans_size_o = CNT_WIDTH'(NB_WORDS);
    case (state_q)
      WAIT_BLOCK: block_ready_o = 1'b1;
      REQUEST: begin
        sink_req_start_o = 1'b1;
        // Byte offset of the current block; wraps modulo 2^32
        sink_base_addr_o = base_q + (32'(blk_cnt_q) << ADDR_SHIFT);
      end
      STREAM: begin
        stream_valid_o = 1'b1;
        stream_data_o  = hold_q[wc_q*WORD_WIDTH +: WORD_WIDTH];
      end
      FINISHED: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
